// File: rtl/fifo_tx_sequencer_if.sv
// Handshake bundle between the block sequencer, its character buffer and the UART.
// master = sequencer side, slave = buffer/UART side.
interface fifo_tx_sequencer_if #(
   parameter int DATA_SIZE = 8
);
   logic                 block_valid;
   logic                 fifo_empty;
   logic [DATA_SIZE-1:0] fifo_data;
   logic                 write_to_fifo;
   logic                 read_from_fifo;
   logic                 tx_ready;
   logic                 tx_start;
   logic [DATA_SIZE-1:0] tx_data;
   logic                 busy;
   logic                 block_done;
   logic                 err;

   modport master (
      input  block_valid, fifo_empty, fifo_data, tx_ready,
      output write_to_fifo, read_from_fifo, tx_start, tx_data, busy, block_done, err
   );

   modport slave (
      output block_valid, fifo_empty, fifo_data, tx_ready,
      input  write_to_fifo, read_from_fifo, tx_start, tx_data, busy, block_done, err
   );
endinterface

// File: rtl/fifo_tx_sequencer.sv
// Streams one ciphertext block of CHAR_COUNT characters from a buffer to a UART.
// Define TX_CRLF_EN to append a CR/LF pair after every block.
module fifo_tx_sequencer #(
   parameter int DATA_SIZE  = 8,
   parameter int CHAR_COUNT = 16
) (
   input logic                  clk_100MHz,
   input logic                  reset_n,
   fifo_tx_sequencer_if.master  bus
);
   localparam int             CW   = $clog2(CHAR_COUNT) + 1;
   localparam logic [CW-1:0]  LAST = CW'(CHAR_COUNT);

   typedef enum logic [3:0] {
      IDLE,
      LOAD,
      WAIT_LOAD,
      SEND,
      WAIT_ACK,
      WAIT_TX,
`ifdef TX_CRLF_EN
      CR,
      LF,
`endif
      DONE
   } state_t;

`ifdef TX_CRLF_EN
   localparam logic [DATA_SIZE-1:0] CR_CHAR = DATA_SIZE'(8'h0D);
   localparam logic [DATA_SIZE-1:0] LF_CHAR = DATA_SIZE'(8'h0A);
   logic [1:0]            tail_reg;
`endif

   state_t                state_reg;
   logic [CW-1:0]         count_reg;
   logic [DATA_SIZE-1:0]  tx_data_reg;
   logic                  tx_start_reg;
   logic                  read_reg;
   logic                  write_reg;
   logic                  busy_reg;
   logic                  done_reg;
   logic                  err_reg;

   always_ff @(posedge clk_100MHz or negedge reset_n) begin
      if (!reset_n) begin
         state_reg    <= IDLE;
         count_reg    <= '0;
         tx_data_reg  <= '0;
         tx_start_reg <= 1'b0;
         read_reg     <= 1'b0;
         write_reg    <= 1'b0;
         busy_reg     <= 1'b0;
         done_reg     <= 1'b0;
         err_reg      <= 1'b0;
`ifdef TX_CRLF_EN
         tail_reg     <= 2'd0;
`endif
      end else begin
         // Strobes are single-cycle: they only rise on the transition that needs them.
         write_reg    <= 1'b0;
         read_reg     <= 1'b0;
         tx_start_reg <= 1'b0;
         done_reg     <= 1'b0;

         // A new block arriving while one is in flight is dropped, not queued.
         if (bus.block_valid && state_reg != IDLE)
            err_reg <= 1'b1;

         case (state_reg)
            IDLE: begin
               if (bus.block_valid) begin
                  state_reg <= LOAD;
                  write_reg <= 1'b1;
                  busy_reg  <= 1'b1;
               end
            end
            LOAD: begin
               count_reg <= '0;
`ifdef TX_CRLF_EN
               tail_reg  <= 2'd0;
`endif
               state_reg <= WAIT_LOAD;
            end
            WAIT_LOAD: begin
               if (!bus.fifo_empty)
                  state_reg <= SEND;
            end
            SEND: begin
               if (bus.fifo_empty && count_reg < LAST) begin
                  err_reg   <= 1'b1;
                  done_reg  <= 1'b1;
                  state_reg <= DONE;
               end else if (bus.tx_ready) begin
                  tx_data_reg  <= bus.fifo_data;
                  tx_start_reg <= 1'b1;
                  read_reg     <= 1'b1;
                  count_reg    <= (count_reg == LAST) ? count_reg : count_reg + CW'(1);
                  state_reg    <= WAIT_ACK;
               end
            end
            WAIT_ACK: begin
               if (!bus.tx_ready)
                  state_reg <= WAIT_TX;
            end
            WAIT_TX: begin
               if (bus.tx_ready) begin
                  if (count_reg < LAST) begin
                     state_reg <= SEND;
                  end else begin
`ifdef TX_CRLF_EN
                     // tail_reg counts trailer bytes already sent.
                     case (tail_reg)
                        2'd0:    state_reg <= CR;
                        2'd1:    state_reg <= LF;
                        default: begin
                           done_reg  <= 1'b1;
                           state_reg <= DONE;
                        end
                     endcase
`else
                     done_reg  <= 1'b1;
                     state_reg <= DONE;
`endif
                  end
               end
            end
`ifdef TX_CRLF_EN
            CR: begin
               if (bus.tx_ready) begin
                  tx_data_reg  <= CR_CHAR;
                  tx_start_reg <= 1'b1;
                  tail_reg     <= 2'd1;
                  state_reg    <= WAIT_ACK;
               end
            end
            LF: begin
               if (bus.tx_ready) begin
                  tx_data_reg  <= LF_CHAR;
                  tx_start_reg <= 1'b1;
                  tail_reg     <= 2'd2;
                  state_reg    <= WAIT_ACK;
               end
            end
`endif
            DONE: begin
               busy_reg  <= 1'b0;
               state_reg <= IDLE;
            end
            default: begin
               busy_reg  <= 1'b0;
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign bus.write_to_fifo  = write_reg;
   assign bus.read_from_fifo = read_reg;
   assign bus.tx_start       = tx_start_reg;
   assign bus.tx_data        = tx_data_reg;
   assign bus.busy           = busy_reg;
   assign bus.block_done     = done_reg;
   assign bus.err            = err_reg;
endmodule
